// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one alu_slave between two requesters (master path = 0,
// slave path = 1). It uses a valid/ready handshake with round-robin
// arbitration and a one-entry result register. The result register adds one
// cycle of latency and supports zero-bubble back-to-back transfers.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    drop the held result, accept nothing this cycle
//   reqN_valid/ready         handshake for requester N (N = 0, 1)
//   reqN_aluop/a/b/tag       operation, operands and opaque tag of requester N
//   out_valid/ready          result register handshake
//   out_src/tag/y/overflow   producing requester, its tag, ALU result, flag
//
// ALU op encoding (mirrors defines.vh ALUOP_*):
//   01 ADD   02 ADDU  03 SUB  04 SUBU  05 SLT  06 SLTU  07 AND
//   08 OR    09 XOR   0A NOR  0B LUI   0C SLL  0D SRL   0E SRA
// Shifts use a[4:0] as the amount and b as the value. LUI places b[15:0] in
// the upper half.

module alu_slave (
    input  logic [7:0]  aluop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y,
    output logic        overflow
);
    localparam logic [7:0] ALUOP_ADD  = 8'h01;
    localparam logic [7:0] ALUOP_ADDU = 8'h02;
    localparam logic [7:0] ALUOP_SUB  = 8'h03;
    localparam logic [7:0] ALUOP_SUBU = 8'h04;
    localparam logic [7:0] ALUOP_SLT  = 8'h05;
    localparam logic [7:0] ALUOP_SLTU = 8'h06;
    localparam logic [7:0] ALUOP_AND  = 8'h07;
    localparam logic [7:0] ALUOP_OR   = 8'h08;
    localparam logic [7:0] ALUOP_XOR  = 8'h09;
    localparam logic [7:0] ALUOP_NOR  = 8'h0A;
    localparam logic [7:0] ALUOP_LUI  = 8'h0B;
    localparam logic [7:0] ALUOP_SLL  = 8'h0C;
    localparam logic [7:0] ALUOP_SRL  = 8'h0D;
    localparam logic [7:0] ALUOP_SRA  = 8'h0E;

    logic [31:0] sum_s;
    logic [31:0] diff_s;

    assign sum_s  = a + b;
    assign diff_s = a - b;

    // Operation decode; unknown codes yield zero with no overflow.
    always_comb begin
        y        = 32'h0000_0000;
        overflow = 1'b0;
        case (aluop)
            ALUOP_ADD: begin
                y        = sum_s;
                // Same-sign operands producing a different-sign sum.
                overflow = (a[31] == b[31]) && (sum_s[31] != a[31]);
            end
            ALUOP_ADDU: y = sum_s;
            ALUOP_SUB: begin
                y        = diff_s;
                overflow = (a[31] != b[31]) && (diff_s[31] != a[31]);
            end
            ALUOP_SUBU: y = diff_s;
            ALUOP_SLT:  y = {31'd0, ($signed(a) < $signed(b))};
            ALUOP_SLTU: y = {31'd0, (a < b)};
            ALUOP_AND:  y = a & b;
            ALUOP_OR:   y = a | b;
            ALUOP_XOR:  y = a ^ b;
            ALUOP_NOR:  y = ~(a | b);
            ALUOP_LUI:  y = {b[15:0], 16'h0000};
            ALUOP_SLL:  y = b << a[4:0];
            ALUOP_SRL:  y = b >> a[4:0];
            ALUOP_SRA:  y = $unsigned($signed(b) >>> a[4:0]);
            default: begin
                y        = 32'h0000_0000;
                overflow = 1'b0;
            end
        endcase
    end
endmodule

module alu_share_arb #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_aluop,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_aluop,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      out_y,
    output logic             out_overflow
);
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              rr_ptr_r;
    logic              grant_s;
    logic              can_accept_s;
    logic              transfer_s;
    logic [7:0]        alu_op_s;
    logic [31:0]       alu_a_s;
    logic [31:0]       alu_b_s;
    logic [TAG_W-1:0]  alu_tag_s;
    logic [31:0]       alu_y_s;
    logic              alu_ovf_s;

    // Arbitration: a lone requester wins; on conflict rr_ptr decides.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = rr_ptr_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // rst gates acceptance so ready stays low while reset is held.
    assign can_accept_s = !rst && !flush && ((state_r == ST_EMPTY) || out_ready);
    assign transfer_s   = req0_ready || req1_ready;

    // Operand mux feeding the single shared ALU.
    always_comb begin
        alu_op_s  = 8'h00;
        alu_a_s   = 32'h0000_0000;
        alu_b_s   = 32'h0000_0000;
        alu_tag_s = '0;
        if (grant_s) begin
            alu_op_s  = req1_aluop;
            alu_a_s   = req1_a;
            alu_b_s   = req1_b;
            alu_tag_s = req1_tag;
        end else begin
            alu_op_s  = req0_aluop;
            alu_a_s   = req0_a;
            alu_b_s   = req0_b;
            alu_tag_s = req0_tag;
        end
    end

    alu_slave u_alu (
        .aluop    (alu_op_s),
        .a        (alu_a_s),
        .b        (alu_b_s),
        .y        (alu_y_s),
        .overflow (alu_ovf_s)
    );

    // Result register FSM: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Result register FSM: next state. A flush wins over delivery and loading.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (flush) begin
                    state_next_s = ST_EMPTY;
                end else if (transfer_s) begin
                    state_next_s = ST_FULL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (flush) begin
                    state_next_s = ST_EMPTY;
                end else if (transfer_s) begin
                    state_next_s = ST_FULL;
                end else if (out_ready) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: state_next_s = ST_EMPTY;
        endcase
    end

    // Result register FSM: outputs decoded from state.
    always_comb begin
        out_valid  = (state_r == ST_FULL);
        req0_ready = can_accept_s && req0_valid && (grant_s == 1'b0);
        req1_ready = can_accept_s && req1_valid && (grant_s == 1'b1);
    end

    // Round-robin pointer: after any transfer it points away from the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= 1'b0;
        end else if (transfer_s) begin
            rr_ptr_r <= ~grant_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Result payload captured only in the transfer cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_src      <= 1'b0;
            out_tag      <= '0;
            out_y        <= 32'h0000_0000;
            out_overflow <= 1'b0;
        end else if (transfer_s) begin
            out_src      <= grant_s;
            out_tag      <= alu_tag_s;
            out_y        <= alu_y_s;
            out_overflow <= alu_ovf_s;
        end else begin
            out_src      <= out_src;
            out_tag      <= out_tag;
            out_y        <= out_y;
            out_overflow <= out_overflow;
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
    localparam int TAG_W = 4;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_ADDU = 8'h02;
    localparam logic [7:0] OP_SUB  = 8'h03;
    localparam logic [7:0] OP_SUBU = 8'h04;
    localparam logic [7:0] OP_SLT  = 8'h05;
    localparam logic [7:0] OP_SLTU = 8'h06;
    localparam logic [7:0] OP_AND  = 8'h07;
    localparam logic [7:0] OP_OR   = 8'h08;
    localparam logic [7:0] OP_XOR  = 8'h09;
    localparam logic [7:0] OP_NOR  = 8'h0A;
    localparam logic [7:0] OP_LUI  = 8'h0B;
    localparam logic [7:0] OP_SLL  = 8'h0C;
    localparam logic [7:0] OP_SRL  = 8'h0D;
    localparam logic [7:0] OP_SRA  = 8'h0E;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             req0_valid = 1'b0;
    logic             req0_ready;
    logic [7:0]       req0_aluop = 8'h00;
    logic [31:0]      req0_a = 32'h0;
    logic [31:0]      req0_b = 32'h0;
    logic [TAG_W-1:0] req0_tag = 4'h0;
    logic             req1_valid = 1'b0;
    logic             req1_ready;
    logic [7:0]       req1_aluop = 8'h00;
    logic [31:0]      req1_a = 32'h0;
    logic [31:0]      req1_b = 32'h0;
    logic [TAG_W-1:0] req1_tag = 4'h0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_src;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      out_y;
    logic             out_overflow;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic             m_valid;
    logic             m_rr;
    logic             m_src;
    logic [TAG_W-1:0] m_tag;
    logic [31:0]      m_y;
    logic             m_ov;

    always #5 clk = ~clk;

    alu_share_arb #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
        .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
        .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
        .out_tag(out_tag), .out_y(out_y), .out_overflow(out_overflow)
    );

    // Behavioural ALU: {overflow, y}
    function automatic logic [32:0] alu_ref(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        logic [31:0] y;
        logic ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        y = 32'h0;
        ov = 1'b0;
        case (op)
            OP_ADD:  begin s = sa + sb; y = a + b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            OP_ADDU: y = a + b;
            OP_SUB:  begin s = sa - sb; y = a - b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            OP_SUBU: y = a - b;
            OP_SLT:  y = (sa < sb) ? 32'd1 : 32'd0;
            OP_SLTU: y = (a < b) ? 32'd1 : 32'd0;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_LUI:  y = b * 32'd65536;
            OP_SLL:  y = b << a[4:0];
            OP_SRL:  y = b >> a[4:0];
            OP_SRA:  y = $unsigned($signed(b) >>> a[4:0]);
            default: y = 32'h0;
        endcase
        return {ov, y};
    endfunction

    // Expected {req1_ready, req0_ready} from the model state and current inputs
    function automatic logic [1:0] exp_ready();
        if (rst || flush || (m_valid && !out_ready)) return 2'b00;
        if (req0_valid && req1_valid) return m_rr ? 2'b10 : 2'b01;
        return {req1_valid, req0_valid};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_rr = 1'b0; m_src = 1'b0; m_tag = '0; m_y = 32'h0; m_ov = 1'b0;
    endtask

    // Advance one clock; model follows the inputs seen at the edge.
    task automatic tick();
        logic [1:0]  er;
        logic [32:0] r;
        @(posedge clk);
        er = exp_ready();
        if (rst) begin
            model_reset();
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (er != 2'b00) begin
            m_src = er[1];
            if (er[1]) begin
                r = alu_ref(req1_aluop, req1_a, req1_b); m_tag = req1_tag;
            end else begin
                r = alu_ref(req0_aluop, req0_a, req0_b); m_tag = req0_tag;
            end
            m_y = r[31:0]; m_ov = r[32];
            m_rr = ~er[1];
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); #1;
        n_vec++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b%b want 00", req1_ready, req0_ready); end
        n_vec++; if ({out_valid, out_src, out_tag, out_y, out_overflow} !== 39'd0) begin n_err++; $display("FAIL reset_out got v=%b s=%b t=%h y=%h o=%b want all 0", out_valid, out_src, out_tag, out_y, out_overflow); end
        idle_inputs();
        tick();
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_aluop = OP_ADD; req0_a = 32'd5; req0_b = 32'd7; req0_tag = 4'd3;
        #1;
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %b want 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        n_vec++; if ({out_valid, out_y, out_src, out_tag, out_overflow} !== {1'b1, 32'd12, 1'b0, 4'd3, 1'b0}) begin
            n_err++; $display("FAIL single_out got v=%b y=%0d s=%b t=%0d o=%b want v=1 y=12 s=0 t=3 o=0", out_valid, out_y, out_src, out_tag, out_overflow); end
        tick();
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        req1_valid = 1'b1; req1_aluop = OP_ADD; req1_a = 32'h7FFF_FFFF; req1_b = 32'd1; req1_tag = 4'd9;
        tick();
        req1_aluop = OP_ADDU;
        #1;
        n_vec++; if ({out_y, out_overflow, out_src} !== {32'h8000_0000, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL ovf_add got y=%h o=%b s=%b want y=80000000 o=1 s=1", out_y, out_overflow, out_src); end
        tick();
        req1_valid = 1'b0;
        #1;
        n_vec++; if ({out_valid, out_y, out_overflow} !== {1'b1, 32'h8000_0000, 1'b0}) begin
            n_err++; $display("FAIL ovf_addu got v=%b y=%h o=%b want v=1 y=80000000 o=0", out_valid, out_y, out_overflow); end
        tick();
    endtask

    task automatic test_round_robin();
        logic        pg;
        logic [3:0]  pt;
        logic [32:0] pr;
        logic        g;
        apply_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_aluop = OP_ADD; req1_aluop = OP_SUB;
        pg = 1'b0; pt = 4'd0; pr = 33'd0;
        for (int i = 0; i < 5; i++) begin
            req0_a = $urandom; req0_b = $urandom; req0_tag = 4'(2 * i);
            req1_a = $urandom; req1_b = $urandom; req1_tag = 4'(2 * i + 1);
            if (i == 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            #1;
            g = i[0];
            if (i < 4) begin
                n_vec++; if ({req1_ready, req0_ready} !== {g, ~g}) begin
                    n_err++; $display("FAIL rr_grant%0d got %b%b want %b%b", i, req1_ready, req0_ready, g, ~g); end
            end
            if (i > 0) begin
                n_vec++; if ({out_valid, out_src, out_tag, out_y, out_overflow} !== {1'b1, pg, pt, pr[31:0], pr[32]}) begin
                    n_err++; $display("FAIL rr_out%0d got s=%b t=%0d y=%h want s=%b t=%0d y=%h", i, out_src, out_tag, out_y, pg, pt, pr[31:0]); end
            end
            pg = g;
            pt = g ? req1_tag : req0_tag;
            pr = g ? alu_ref(req1_aluop, req1_a, req1_b) : alu_ref(req0_aluop, req0_a, req0_b);
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] hy;
        logic [3:0]  ht;
        idle_inputs();
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_aluop = OP_XOR; req0_a = 32'hF0F0_1234; req0_b = 32'h0FF0_4321; req0_tag = 4'd5;
        #1;
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_first got %b want 1", req0_ready); end
        tick();
        hy = 32'hF0F0_1234 ^ 32'h0FF0_4321; ht = 4'd5;
        for (int i = 0; i < 3; i++) begin
            req0_a = $urandom; req0_tag = 4'd6;
            #1;
            n_vec++; if ({req0_ready, out_valid, out_y, out_tag} !== {1'b0, 1'b1, hy, ht}) begin
                n_err++; $display("FAIL bp_hold%0d got r=%b v=%b y=%h t=%0d want r=0 v=1 y=%h t=%0d", i, req0_ready, out_valid, out_y, out_tag, hy, ht); end
            tick();
        end
        out_ready = 1'b1; req0_aluop = OP_OR; req0_a = 32'h1; req0_b = 32'h2;
        #1;
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got %b want 1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        n_vec++; if ({out_valid, out_y, out_tag} !== {1'b1, 32'h3, 4'd6}) begin
            n_err++; $display("FAIL bp_next got v=%b y=%h t=%0d want v=1 y=3 t=6", out_valid, out_y, out_tag); end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        req1_valid = 1'b1; req1_aluop = OP_AND; req1_a = 32'hFF; req1_b = 32'h0F; req1_tag = 4'd2;
        tick();
        flush = 1'b1;
        #1;
        n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready got %b want 0", req1_ready); end
        tick();
        flush = 1'b0; req1_valid = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", out_valid); end
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        req1_valid = 1'b1; req1_aluop = OP_SUB; req1_a = 32'd10; req1_b = 32'd3; req1_tag = 4'd7;
        tick();
        req1_valid = 1'b0;
        #2; rst = 1'b1; #1;
        n_vec++; if ({out_valid, out_src, out_tag, out_y, out_overflow} !== 39'd0) begin
            n_err++; $display("FAIL async_rst got v=%b s=%b t=%h y=%h o=%b want all 0", out_valid, out_src, out_tag, out_y, out_overflow); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        out_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_vec++; if ({req1_ready, req0_ready} !== 2'b01) begin
            n_err++; $display("FAIL async_rst_prio got %b%b want 01", req1_ready, req0_ready); end
        tick();
        idle_inputs();
        tick();
    endtask

    function automatic logic [7:0] rand_op();
        int k;
        k = $urandom_range(0, 15);
        return (k == 15) ? 8'hA5 : 8'(k);
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 4))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [1:0] er;
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 11) == 0);
            req0_aluop = rand_op(); req0_a = rand_word(); req0_b = rand_word(); req0_tag = 4'($urandom);
            req1_aluop = rand_op(); req1_a = rand_word(); req1_b = rand_word(); req1_tag = 4'($urandom);
            #1;
            er = exp_ready();
            n_vec++; if ({req1_ready, req0_ready} !== er) begin
                n_err++; $display("FAIL rand_ready%0d got %b%b want %b", i, req1_ready, req0_ready, er); end
            n_vec++; if (out_valid !== m_valid) begin
                n_err++; $display("FAIL rand_valid%0d got %b want %b", i, out_valid, m_valid); end
            if (m_valid) begin
                n_vec++; if ({out_src, out_tag, out_y, out_overflow} !== {m_src, m_tag, m_y, m_ov}) begin
                    n_err++; $display("FAIL rand_out%0d got s=%b t=%h y=%h o=%b want s=%b t=%h y=%h o=%b",
                        i, out_src, out_tag, out_y, out_overflow, m_src, m_tag, m_y, m_ov); end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
